// File: rtl/unidade_controle_multiciclo_pkg.sv
// ---------------------------------------------------------------------------
// unidade_controle_multiciclo_pkg
// Shared definitions for the multicycle control unit and its decoder:
//   - FSM state codes (also exported on the debug port 'estado')
//   - RV64 opcode and funct3 constants for the supported subset
//   - ALU 'operacao' codes, shared with the 64-bit ALU
//   - instruction class enum registered in DECODIFICA
// ---------------------------------------------------------------------------
package unidade_controle_multiciclo_pkg;

    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        MEMORIA    = 3'd3,
        ESCRITA    = 3'd4,
        ERRO       = 3'd5
    } estado_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LD_SD   = 3'b011;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;

    localparam logic [1:0] OPER_S   = 2'd0;
    localparam logic [1:0] OPER_AND = 2'd1;
    localparam logic [1:0] OPER_OR  = 2'd2;

    typedef enum logic [2:0] {
        CLASSE_NENHUMA = 3'd0,
        CLASSE_ALU_R   = 3'd1,
        CLASSE_ALU_I   = 3'd2,
        CLASSE_LOAD    = 3'd3,
        CLASSE_STORE   = 3'd4,
        CLASSE_BRANCH  = 3'd5
    } classe_t;

endpackage

// File: rtl/unidade_controle_multiciclo_decodificador.sv
// ---------------------------------------------------------------------------
// decodificador_instrucao
// Purely combinational instruction decoder.
//   opcode, funct3, funct7_5 : instruction fields from the IR
//   classe     : instruction class (classe_t encoding)
//   legal      : 1 when the encoding belongs to the supported subset
//   operacao   : ALU operation code (S / AND / OR)
//   subtraindo : ALU subtract select
//   alu_src    : ALU second operand, 0 = rs2, 1 = immediate
// ---------------------------------------------------------------------------
module decodificador_instrucao
    import unidade_controle_multiciclo_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] classe,
    output logic       legal,
    output logic [1:0] operacao,
    output logic       subtraindo,
    output logic       alu_src
);

    classe_t classe_int;

    always_comb begin
        classe_int = CLASSE_NENHUMA;
        legal      = 1'b0;
        operacao   = OPER_S;
        subtraindo = 1'b0;
        alu_src    = 1'b0;

        unique case (opcode)
            OP_R: begin
                classe_int = CLASSE_ALU_R;
                case (funct3)
                    F3_ADD_SUB: begin
                        legal      = 1'b1;
                        subtraindo = funct7_5;
                    end
                    F3_AND: begin
                        legal    = ~funct7_5;
                        operacao = OPER_AND;
                    end
                    F3_OR: begin
                        legal    = ~funct7_5;
                        operacao = OPER_OR;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_I: begin
                // Immediate forms never subtract; bit 30 is part of the immediate.
                classe_int = CLASSE_ALU_I;
                alu_src    = 1'b1;
                case (funct3)
                    F3_ADD_SUB: legal = 1'b1;
                    F3_AND: begin
                        legal    = 1'b1;
                        operacao = OPER_AND;
                    end
                    F3_OR: begin
                        legal    = 1'b1;
                        operacao = OPER_OR;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                classe_int = CLASSE_LOAD;
                alu_src    = 1'b1;
                legal      = (funct3 == F3_LD_SD);
            end
            OP_STORE: begin
                classe_int = CLASSE_STORE;
                alu_src    = 1'b1;
                legal      = (funct3 == F3_LD_SD);
            end
            OP_BRANCH: begin
                // Branches compare rs1 - rs2; funct3 010/011 are unused.
                classe_int = CLASSE_BRANCH;
                subtraindo = 1'b1;
                legal      = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            default: legal = 1'b0;
        endcase
    end

    assign classe = classe_int;

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// ---------------------------------------------------------------------------
// unidade_controle_multiciclo
// Multicycle control FSM for the RV64 subset (add/sub/and/or, addi/andi/ori,
// ld, sd, beq/bne/blt/bge/bltu/bgeu). Drives the ALU controls, owns the
// instruction- and data-memory req/ack handshakes, and strobes IR/PC/regfile.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   opcode, funct3, funct7_5      : IR fields
//   flag_igual/menor/maior_igual_u: ALU compare flags (branch resolution)
//   flag_overflow                 : ALU carry-out, not used for sequencing
//   imem_req/imem_ack             : instruction fetch handshake
//   dmem_req/dmem_we/dmem_ack     : data access handshake
//   ir_load, pc_load, pc_src      : IR capture, PC update and PC source
//   alu_src, subtraindo, operacao : ALU controls
//   reg_write, mem_to_reg         : register file writeback controls
//   ilegal                        : sticky error (ERRO state)
//   estado                        : current state code, debug
// TIMEOUT_CICLOS (1..255): cycles a req may wait for its ack before ERRO.
// ---------------------------------------------------------------------------
module unidade_controle_multiciclo
    import unidade_controle_multiciclo_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       flag_igual,
    input  logic       flag_menor,
    input  logic       flag_maior_igual_u,
    input  logic       flag_overflow,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       ir_load,
    output logic       pc_load,
    output logic       pc_src,
    output logic       alu_src,
    output logic       subtraindo,
    output logic [1:0] operacao,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       ilegal,
    output logic [2:0] estado
);

    // Counter value on the last allowed waiting cycle: if the ack is still
    // low on that edge the wait has lasted TIMEOUT_CICLOS cycles.
    localparam logic [7:0] LIMITE_ESPERA = 8'(TIMEOUT_CICLOS - 1);

    estado_t    estado_q, estado_d;
    classe_t    classe_q;
    logic [7:0] contador_q, contador_d;
    logic [2:0] funct3_q;
    logic [1:0] operacao_q;
    logic       subtraindo_q;
    logic       alu_src_q;

    logic [2:0] dec_classe;
    logic       dec_legal;
    logic [1:0] dec_operacao;
    logic       dec_subtraindo;
    logic       dec_alu_src;

    logic       desvio_tomado;
    logic       alu_ativa;
    logic       imem_req_c, dmem_req_c, dmem_we_c, ir_load_c, pc_load_c;
    logic       pc_src_c, reg_write_c, mem_to_reg_c, ilegal_c;

    // The carry-out is deliberately ignored: no overflow trap in this core.
    logic       flag_overflow_unused;
    assign flag_overflow_unused = flag_overflow;

    decodificador_instrucao u_decodificador (
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .classe     (dec_classe),
        .legal      (dec_legal),
        .operacao   (dec_operacao),
        .subtraindo (dec_subtraindo),
        .alu_src    (dec_alu_src)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= BUSCA;
            classe_q     <= CLASSE_NENHUMA;
            contador_q   <= '0;
            funct3_q     <= '0;
            operacao_q   <= OPER_S;
            subtraindo_q <= 1'b0;
            alu_src_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            contador_q <= contador_d;
            // Decode results are frozen so the ALU controls stay stable
            // for the rest of the instruction.
            if (estado_q == DECODIFICA) begin
                classe_q     <= classe_t'(dec_classe);
                funct3_q     <= funct3;
                operacao_q   <= dec_operacao;
                subtraindo_q <= dec_subtraindo;
                alu_src_q    <= dec_alu_src;
            end
        end
    end

    always_comb begin
        desvio_tomado = 1'b0;
        case (funct3_q)
            F3_BEQ:  desvio_tomado = flag_igual;
            F3_BNE:  desvio_tomado = ~flag_igual;
            F3_BLT:  desvio_tomado = flag_menor;
            F3_BGE:  desvio_tomado = ~flag_menor;
            F3_BLTU: desvio_tomado = ~flag_maior_igual_u;
            F3_BGEU: desvio_tomado = flag_maior_igual_u;
            default: desvio_tomado = 1'b0;
        endcase
    end

    always_comb begin
        estado_d     = estado_q;
        contador_d   = '0;   // any state change clears the wait counter
        alu_ativa    = 1'b0;
        imem_req_c   = 1'b0;
        dmem_req_c   = 1'b0;
        dmem_we_c    = 1'b0;
        ir_load_c    = 1'b0;
        pc_load_c    = 1'b0;
        pc_src_c     = 1'b0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        ilegal_c     = 1'b0;

        case (estado_q)
            BUSCA: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_load_c = 1'b1;
                    estado_d  = DECODIFICA;
                end else if (contador_q == LIMITE_ESPERA) begin
                    estado_d = ERRO;
                end else begin
                    contador_d = contador_q + 8'd1;
                end
            end
            DECODIFICA: begin
                estado_d = dec_legal ? EXECUTA : ERRO;
            end
            EXECUTA: begin
                alu_ativa = 1'b1;
                case (classe_q)
                    CLASSE_ALU_R, CLASSE_ALU_I: estado_d = ESCRITA;
                    CLASSE_LOAD, CLASSE_STORE:  estado_d = MEMORIA;
                    CLASSE_BRANCH: begin
                        pc_load_c = 1'b1;
                        pc_src_c  = desvio_tomado;
                        estado_d  = BUSCA;
                    end
                    default: estado_d = ERRO;
                endcase
            end
            MEMORIA: begin
                alu_ativa  = 1'b1;
                dmem_req_c = 1'b1;
                dmem_we_c  = (classe_q == CLASSE_STORE);
                if (dmem_ack) begin
                    if (classe_q == CLASSE_STORE) begin
                        pc_load_c = 1'b1;
                        estado_d  = BUSCA;
                    end else begin
                        estado_d = ESCRITA;
                    end
                end else if (contador_q == LIMITE_ESPERA) begin
                    estado_d = ERRO;
                end else begin
                    contador_d = contador_q + 8'd1;
                end
            end
            ESCRITA: begin
                alu_ativa    = 1'b1;
                reg_write_c  = 1'b1;
                mem_to_reg_c = (classe_q == CLASSE_LOAD);
                pc_load_c    = 1'b1;
                estado_d     = BUSCA;
            end
            ERRO: begin
                ilegal_c = 1'b1;
            end
            default: estado_d = ERRO;
        endcase
    end

    // Outputs are qualified with rst_n: the registers reset to BUSCA, whose
    // imem_req would otherwise be visible while reset is still asserted.
    assign imem_req   = rst_n & imem_req_c;
    assign dmem_req   = rst_n & dmem_req_c;
    assign dmem_we    = rst_n & dmem_we_c;
    assign ir_load    = rst_n & ir_load_c;
    assign pc_load    = rst_n & pc_load_c;
    assign pc_src     = rst_n & pc_src_c;
    assign reg_write  = rst_n & reg_write_c;
    assign mem_to_reg = rst_n & mem_to_reg_c;
    assign ilegal     = rst_n & ilegal_c;
    assign alu_src    = rst_n & alu_ativa & alu_src_q;
    assign subtraindo = rst_n & alu_ativa & subtraindo_q;
    assign operacao   = (rst_n && alu_ativa) ? operacao_q : OPER_S;
    assign estado     = estado_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
module tb_unidade_controle_multiciclo;

    localparam int TIMEOUT = 255;
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_SD = 3, K_BR = 4;
    localparam int DC = 2;   // funct7_5 don't-care in the instruction table

    typedef struct {
        string      m;
        logic [6:0] op;
        logic [2:0] f3;
        int         f75;
        int         tipo;
    } instr_t;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_load;
        logic       pc_load;
        logic       pc_src;
        logic       alu_src;
        logic       subtraindo;
        logic [1:0] operacao;
        logic       reg_write;
        logic       mem_to_reg;
        logic       ilegal;
        logic [2:0] estado;
    } saidas_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       flag_igual, flag_menor, flag_maior_igual_u, flag_overflow;
    logic       imem_ack, dmem_ack;
    logic       imem_req, dmem_req, dmem_we, ir_load, pc_load, pc_src;
    logic       alu_src, subtraindo, reg_write, mem_to_reg, ilegal;
    logic [1:0] operacao;
    logic [2:0] estado;

    int checks   = 0;
    int failures = 0;
    instr_t tab [15];

    always #5 clk = ~clk;

    unidade_controle_multiciclo #(.TIMEOUT_CICLOS(TIMEOUT)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .opcode             (opcode),
        .funct3             (funct3),
        .funct7_5           (funct7_5),
        .flag_igual         (flag_igual),
        .flag_menor         (flag_menor),
        .flag_maior_igual_u (flag_maior_igual_u),
        .flag_overflow      (flag_overflow),
        .imem_req           (imem_req),
        .imem_ack           (imem_ack),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_ack           (dmem_ack),
        .ir_load            (ir_load),
        .pc_load            (pc_load),
        .pc_src             (pc_src),
        .alu_src            (alu_src),
        .subtraindo         (subtraindo),
        .operacao           (operacao),
        .reg_write          (reg_write),
        .mem_to_reg         (mem_to_reg),
        .ilegal             (ilegal),
        .estado             (estado)
    );

    task automatic verifica(input string tag, input logic [15:0] obs, input logic [15:0] esp);
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    function automatic saidas_t obs_saidas();
        saidas_t s;
        s.imem_req   = imem_req;
        s.dmem_req   = dmem_req;
        s.dmem_we    = dmem_we;
        s.ir_load    = ir_load;
        s.pc_load    = pc_load;
        s.pc_src     = pc_src;
        s.alu_src    = alu_src;
        s.subtraindo = subtraindo;
        s.operacao   = operacao;
        s.reg_write  = reg_write;
        s.mem_to_reg = mem_to_reg;
        s.ilegal     = ilegal;
        s.estado     = estado;
        return s;
    endfunction

    // Inputs are set at the falling edge; outputs are checked 2 units later.
    task automatic ciclo(input string tag, input saidas_t e);
        flag_overflow = 1'($urandom);
        #2;
        verifica(tag, obs_saidas(), e);
        @(negedge clk);
    endtask

    function automatic int busca_tab(input logic [6:0] op, input logic [2:0] f3, input logic f75);
        for (int i = 0; i < 15; i++)
            if (tab[i].op == op && tab[i].f3 == f3 && (tab[i].f75 == DC || tab[i].f75 == int'(f75)))
                return i;
        return -1;
    endfunction

    task automatic codifica(input string m, output logic [6:0] op, output logic [2:0] f3, output logic f75);
        op = '0; f3 = '0; f75 = 1'b0;
        for (int i = 0; i < 15; i++)
            if (tab[i].m == m) begin
                op  = tab[i].op;
                f3  = tab[i].f3;
                f75 = (tab[i].f75 == DC) ? 1'($urandom) : tab[i].f75[0];
            end
    endtask

    task automatic aplica_reset();
        rst_n = 1'b0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        #1;
        verifica("reset", obs_saidas(), '0);
        @(negedge clk);
        #2;
        verifica("reset_hold", obs_saidas(), '0);
        @(negedge clk);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic checa_erro(input string tag);
        saidas_t e;
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'($urandom);
            dmem_ack = 1'($urandom);
            e = '0;
            e.ilegal = 1'b1;
            e.estado = 3'd5;
            ciclo(tag, e);
        end
    endtask

    // One instruction from fetch to the next fetch, cycle by cycle.
    // flags: -1 random, else {igual, menor, maior_igual_u}.
    // aborta: MEMORIA wait cycle in which rst_n is pulsed (-1 none).
    task automatic executa(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input int n_imem, input int n_dmem, input int flags,
                           input int aborta, output bit erro);
        saidas_t e, alu;
        int      idx;
        string   m;
        bit      tomado;
        erro = 1'b0;
        idx  = busca_tab(op, f3, f75);

        for (int i = 0; i < n_imem && i < TIMEOUT; i++) begin
            imem_ack = 1'b0;
            dmem_ack = 1'($urandom);
            e = '0; e.imem_req = 1'b1;
            ciclo("busca_espera", e);
        end
        if (n_imem >= TIMEOUT) begin
            checa_erro("timeout_imem");
            erro = 1'b1;
            return;
        end
        imem_ack = 1'b1;
        dmem_ack = 1'($urandom);
        opcode = op; funct3 = f3; funct7_5 = f75;
        e = '0; e.imem_req = 1'b1; e.ir_load = 1'b1;
        ciclo("busca_ack", e);

        imem_ack = 1'($urandom);
        dmem_ack = 1'($urandom);
        e = '0; e.estado = 3'd1;
        ciclo("decodifica", e);
        if (idx < 0) begin
            checa_erro("ilegal");
            erro = 1'b1;
            return;
        end

        m = tab[idx].m;
        alu = '0;
        alu.alu_src    = (tab[idx].tipo != K_R) && (tab[idx].tipo != K_BR);
        alu.subtraindo = (m == "sub") || (tab[idx].tipo == K_BR);
        alu.operacao   = (m == "and" || m == "andi") ? 2'd1 :
                         (m == "or"  || m == "ori")  ? 2'd2 : 2'd0;

        if (flags < 0) begin
            flag_igual = 1'($urandom); flag_menor = 1'($urandom); flag_maior_igual_u = 1'($urandom);
        end else begin
            flag_igual = flags[2]; flag_menor = flags[1]; flag_maior_igual_u = flags[0];
        end
        imem_ack = 1'($urandom);
        dmem_ack = 1'($urandom);
        e = alu; e.estado = 3'd2;
        if (tab[idx].tipo == K_BR) begin
            tomado = (m == "beq")  ?  flag_igual :
                     (m == "bne")  ? !flag_igual :
                     (m == "blt")  ?  flag_menor :
                     (m == "bge")  ? !flag_menor :
                     (m == "bltu") ? !flag_maior_igual_u : flag_maior_igual_u;
            e.pc_load = 1'b1;
            e.pc_src  = tomado;
            ciclo({"executa_", m}, e);
            return;
        end
        ciclo({"executa_", m}, e);

        if (tab[idx].tipo == K_LD || tab[idx].tipo == K_SD) begin
            for (int i = 0; i < n_dmem && i < TIMEOUT; i++) begin
                dmem_ack = 1'b0;
                imem_ack = 1'($urandom);
                e = alu; e.dmem_req = 1'b1; e.dmem_we = (tab[idx].tipo == K_SD); e.estado = 3'd3;
                if (i == aborta) begin
                    #2;
                    verifica("memoria_espera", obs_saidas(), e);
                    #1 rst_n = 1'b0;
                    #1 verifica("reset_assinc", obs_saidas(), '0);
                    @(negedge clk);
                    #2 verifica("reset_memoria", obs_saidas(), '0);
                    @(negedge clk);
                    imem_ack = 1'b0;
                    dmem_ack = 1'b0;
                    rst_n = 1'b1;
                    return;
                end
                ciclo("memoria_espera", e);
            end
            if (n_dmem >= TIMEOUT) begin
                checa_erro("timeout_dmem");
                erro = 1'b1;
                return;
            end
            dmem_ack = 1'b1;
            imem_ack = 1'($urandom);
            e = alu; e.dmem_req = 1'b1; e.dmem_we = (tab[idx].tipo == K_SD); e.estado = 3'd3;
            e.pc_load = (tab[idx].tipo == K_SD);
            ciclo("memoria_ack", e);
            if (tab[idx].tipo == K_SD) return;
        end

        imem_ack = 1'($urandom);
        dmem_ack = 1'($urandom);
        e = alu; e.reg_write = 1'b1; e.mem_to_reg = (tab[idx].tipo == K_LD);
        e.pc_load = 1'b1; e.estado = 3'd4;
        ciclo({"escrita_", m}, e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic       f75;
        bit         erro;

        tab[0]  = '{"add",  7'b0110011, 3'b000, 0,  K_R};
        tab[1]  = '{"sub",  7'b0110011, 3'b000, 1,  K_R};
        tab[2]  = '{"and",  7'b0110011, 3'b111, 0,  K_R};
        tab[3]  = '{"or",   7'b0110011, 3'b110, 0,  K_R};
        tab[4]  = '{"addi", 7'b0010011, 3'b000, DC, K_I};
        tab[5]  = '{"andi", 7'b0010011, 3'b111, DC, K_I};
        tab[6]  = '{"ori",  7'b0010011, 3'b110, DC, K_I};
        tab[7]  = '{"ld",   7'b0000011, 3'b011, DC, K_LD};
        tab[8]  = '{"sd",   7'b0100011, 3'b011, DC, K_SD};
        tab[9]  = '{"beq",  7'b1100011, 3'b000, DC, K_BR};
        tab[10] = '{"bne",  7'b1100011, 3'b001, DC, K_BR};
        tab[11] = '{"blt",  7'b1100011, 3'b100, DC, K_BR};
        tab[12] = '{"bge",  7'b1100011, 3'b101, DC, K_BR};
        tab[13] = '{"bltu", 7'b1100011, 3'b110, DC, K_BR};
        tab[14] = '{"bgeu", 7'b1100011, 3'b111, DC, K_BR};

        opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        flag_igual = 1'b0; flag_menor = 1'b0; flag_maior_igual_u = 1'b0; flag_overflow = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;

        aplica_reset();

        // Directed sequences
        codifica("sub", op, f3, f75);
        executa(op, f3, f75, 3, 0, -1, -1, erro);
        codifica("bltu", op, f3, f75);
        executa(op, f3, f75, 0, 0, 3'b000, -1, erro);
        executa(op, f3, f75, 0, 0, 3'b001, -1, erro);
        codifica("bne", op, f3, f75);
        executa(op, f3, f75, 0, 0, 3'b100, -1, erro);
        codifica("ld", op, f3, f75);
        executa(op, f3, f75, 0, 2, -1, -1, erro);
        codifica("sd", op, f3, f75);
        executa(op, f3, f75, 1, 0, -1, -1, erro);
        codifica("ld", op, f3, f75);
        executa(op, f3, f75, 0, TIMEOUT - 1, -1, -1, erro);   // ack on the last edge wins

        executa(7'b1111111, 3'b000, 1'b0, 0, 0, -1, -1, erro);
        if (erro) aplica_reset();
        codifica("ld", op, f3, f75);
        executa(op, f3, f75, 0, TIMEOUT, -1, -1, erro);
        if (erro) aplica_reset();
        codifica("add", op, f3, f75);
        executa(op, f3, f75, TIMEOUT, 0, -1, -1, erro);
        if (erro) aplica_reset();

        codifica("ld", op, f3, f75);
        executa(op, f3, f75, 0, 3, -1, 1, erro);
        codifica("add", op, f3, f75);
        executa(op, f3, f75, 0, 0, -1, -1, erro);

        // Randomized instruction stream
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 4) != 0) begin
                codifica(tab[$urandom_range(0, 14)].m, op, f3, f75);
            end else begin
                case ($urandom_range(0, 5))
                    0: op = 7'b0110011;
                    1: op = 7'b0010011;
                    2: op = 7'b0000011;
                    3: op = 7'b0100011;
                    4: op = 7'b1100011;
                    default: op = 7'($urandom);
                endcase
                f3  = 3'($urandom);
                f75 = 1'($urandom);
            end
            executa(op, f3, f75, $urandom_range(0, 3), $urandom_range(0, 3), -1, -1, erro);
            if (erro) aplica_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
